bird_physics: RTL and testbench

//  Vertical motion engine for the bird sprite: gravity, flap impulse, terminal velocity,

---
 rtl/bird_physics.sv | 142 ++++++++++++++
 tb/tb_bird_physics.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bird_physics.sv
// bird_physics
//   Vertical motion engine for the bird sprite. It applies gravity, a flap
//   impulse and a terminal velocity, clamps the bird at the ceiling and the
//   floor, and tracks the IDLE / PLAY / DEAD game state. Motion only advances
//   on enable (frame tick) cycles. Button rising edges are captured on every
//   clk cycle and held pending until the next tick.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-low reset
//   enable       in   1   frame-tick pulse, one clk wide
//   start_button in   1   synchronised start level
//   flap_button  in   1   synchronised flap level
//   collided     in   1   pipe-collision flag from the collision stage
//   bird_y       out  10  bird top-edge row
//   bird_vy      out  6   signed velocity, positive = downward
//   game_state   out  2   00 IDLE, 01 PLAY, 10 DEAD (11 behaves as IDLE)
//   hit_ground   out  1   high while DEAD because the bird reached the floor
module bird_physics #(
  parameter logic [9:0] BIRD_Y_START = 10'd240,
  parameter logic [5:0] GRAVITY      = 6'd1,
  parameter logic [5:0] FLAP_IMPULSE = 6'd8,
  parameter logic [5:0] MAX_FALL     = 6'd10,
  parameter logic [9:0] CEILING_Y    = 10'd0,
  parameter logic [9:0] FLOOR_Y      = 10'd464
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start_button,
  input  logic              flap_button,
  input  logic              collided,
  output logic [9:0]        bird_y,
  output logic signed [5:0] bird_vy,
  output logic [1:0]        game_state,
  output logic              hit_ground
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DEAD = 2'b10
  } state_t;

  state_t            r_state, w_state_n;
  logic [9:0]        r_y, w_y_n;
  logic signed [5:0] r_vy, w_vy_n;
  logic              r_hit, w_hit_n;
  logic              r_flap_d, r_start_d;
  logic              r_flap_pend, r_start_pend;

  logic              w_flap, w_start;
  logic signed [6:0] w_vy_inc;
  logic signed [5:0] w_vy_fall;
  logic signed [5:0] w_vy_next;
  logic signed [11:0] w_y_sum;

  // An edge arriving in the same cycle as the tick counts for that tick.
  assign w_flap  = r_flap_pend  | (flap_button  & ~r_flap_d);
  assign w_start = r_start_pend | (start_button & ~r_start_d);

  // Gravity step with terminal-velocity cap; 7-bit sum so the compare
  // cannot overflow before the cap is applied.
  assign w_vy_inc  = {r_vy[5], r_vy} + $signed({1'b0, GRAVITY});
  assign w_vy_fall = (w_vy_inc > $signed({1'b0, MAX_FALL})) ? $signed(MAX_FALL)
                                                            : w_vy_inc[5:0];
  assign w_vy_next = w_flap ? -$signed(FLAP_IMPULSE) : w_vy_fall;

  // 12-bit signed position so going above row 0 is seen as negative.
  assign w_y_sum = $signed({2'b00, r_y}) + {{6{w_vy_next[5]}}, w_vy_next};

  always_comb begin
    w_state_n = r_state;
    w_y_n     = r_y;
    w_vy_n    = r_vy;
    w_hit_n   = r_hit;
    if (enable) begin
      case (r_state)
        S_PLAY: begin
          if (collided) begin
            w_state_n = S_DEAD;
          end else if (w_y_sum <= $signed({2'b00, CEILING_Y})) begin
            w_y_n  = CEILING_Y;
            w_vy_n = '0;
          end else if (w_y_sum >= $signed({2'b00, FLOOR_Y})) begin
            w_y_n     = FLOOR_Y;
            w_vy_n    = '0;
            w_hit_n   = 1'b1;
            w_state_n = S_DEAD;
          end else begin
            w_y_n  = w_y_sum[9:0];
            w_vy_n = w_vy_next;
          end
        end
        S_DEAD: begin
          if (w_start) begin
            w_state_n = S_IDLE;
            w_y_n     = BIRD_Y_START;
            w_vy_n    = '0;
            w_hit_n   = 1'b0;
          end
        end
        default: begin
          // IDLE, and the unused encoding, park the bird at its start row.
          w_y_n     = BIRD_Y_START;
          w_vy_n    = '0;
          w_hit_n   = 1'b0;
          w_state_n = w_start ? S_PLAY : S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_y          <= BIRD_Y_START;
      r_vy         <= '0;
      r_hit        <= 1'b0;
      r_flap_d     <= 1'b0;
      r_start_d    <= 1'b0;
      r_flap_pend  <= 1'b0;
      r_start_pend <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_y          <= w_y_n;
      r_vy         <= w_vy_n;
      r_hit        <= w_hit_n;
      r_flap_d     <= flap_button;
      r_start_d    <= start_button;
      // Pending flags last only until the next tick, used or not.
      r_flap_pend  <= enable ? 1'b0 : w_flap;
      r_start_pend <= enable ? 1'b0 : w_start;
    end
  end

  assign bird_y     = r_y;
  assign bird_vy    = r_vy;
  assign game_state = r_state;
  assign hit_ground = r_hit;

endmodule

// File: tb/tb_bird_physics.sv
// Testbench for bird_physics: a vector table of directed frames, hand-written
// floor/ceiling/reset sequences, and a randomized run against a reference model.
module tb_bird_physics;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              start_button = 1'b0;
  logic              flap_button = 1'b0;
  logic              collided = 1'b0;
  logic [9:0]        bird_y;
  logic signed [5:0] bird_vy;
  logic [1:0]        game_state;
  logic              hit_ground;

  int n_total = 0;
  int n_pass  = 0;

  bird_physics dut (
    .clk(clk), .reset(reset), .enable(enable), .start_button(start_button),
    .flap_button(flap_button), .collided(collided), .bird_y(bird_y),
    .bird_vy(bird_vy), .game_state(game_state), .hit_ground(hit_ground)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s, f, c, e;
    int   y, vy, st, hit;
  } vec_t;

  vec_t tbl[24];

  // Reference model state (plain integers, game rules applied directly).
  int m_y, m_vy, m_st, m_hit;
  bit m_fp, m_sp, m_fprev, m_sprev;

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic chk_all(input string nm, input int y, input int vy,
                         input int st, input int hit);
    chk({nm, ".y"},   int'(bird_y), y);
    chk({nm, ".vy"},  int'(bird_vy), vy);
    chk({nm, ".st"},  int'(game_state), st);
    chk({nm, ".hit"}, int'(hit_ground), hit);
  endtask

  // Apply inputs for one clk cycle, then sample just after the edge.
  task automatic cyc(input logic s, input logic f, input logic c, input logic e);
    start_button = s; flap_button = f; collided = c; enable = e;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_y = 240; m_vy = 0; m_st = 0; m_hit = 0;
    m_fp = 0; m_sp = 0; m_fprev = 0; m_sprev = 0;
  endtask

  task automatic model_step(input bit s, input bit f, input bit c, input bit e);
    bit fp, sp;
    int vy, yn;
    fp = m_fp | (f & ~m_fprev);
    sp = m_sp | (s & ~m_sprev);
    m_fprev = f;
    m_sprev = s;
    if (!e) begin
      m_fp = fp;
      m_sp = sp;
      return;
    end
    m_fp = 0;
    m_sp = 0;
    if (m_st == 1) begin
      if (c) m_st = 2;
      else begin
        vy = fp ? -8 : ((m_vy + 1 > 10) ? 10 : m_vy + 1);
        yn = m_y + vy;
        if (yn <= 0) begin m_y = 0; m_vy = 0; end
        else if (yn >= 464) begin m_y = 464; m_vy = 0; m_hit = 1; m_st = 2; end
        else begin m_y = yn; m_vy = vy; end
      end
    end else if (m_st == 2) begin
      if (sp) begin m_st = 0; m_y = 240; m_vy = 0; m_hit = 0; end
    end else begin
      m_y = 240; m_vy = 0; m_hit = 0;
      if (sp) m_st = 1;
    end
  endtask

  initial begin
    //           s  f  c  e   y    vy  st hit
    tbl[0]  = '{0, 0, 0, 1, 240,  0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 240,  0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 240,  0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 240,  0, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 240,  0, 1, 0};
    tbl[5]  = '{0, 0, 0, 1, 241,  1, 1, 0};
    tbl[6]  = '{0, 0, 0, 1, 243,  2, 1, 0};
    tbl[7]  = '{0, 0, 0, 1, 246,  3, 1, 0};
    tbl[8]  = '{0, 0, 0, 1, 250,  4, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, 250,  4, 1, 0};
    tbl[10] = '{0, 1, 0, 1, 242, -8, 1, 0};
    tbl[11] = '{0, 1, 0, 1, 235, -7, 1, 0};
    tbl[12] = '{0, 1, 0, 1, 229, -6, 1, 0};
    tbl[13] = '{0, 1, 0, 1, 224, -5, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 224, -5, 1, 0};
    tbl[15] = '{0, 1, 0, 1, 216, -8, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 216, -8, 1, 0};
    tbl[17] = '{0, 1, 1, 1, 216, -8, 2, 0};
    tbl[18] = '{0, 0, 0, 1, 216, -8, 2, 0};
    tbl[19] = '{1, 0, 0, 1, 240,  0, 0, 0};
    tbl[20] = '{1, 0, 0, 1, 240,  0, 0, 0};
    tbl[21] = '{0, 0, 0, 1, 240,  0, 0, 0};
    tbl[22] = '{1, 0, 0, 1, 240,  0, 1, 0};
    tbl[23] = '{0, 1, 0, 1, 232, -8, 1, 0};

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 240, 0, 0, 0);
    reset = 1'b1;

    // Directed frame table
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].s, tbl[i].f, tbl[i].c, tbl[i].e);
      chk_all($sformatf("vec%0d", i), tbl[i].y, tbl[i].vy, tbl[i].st, tbl[i].hit);
    end

    // Floor: free fall from the start row until the floor clamp kills the bird
    cyc(0, 0, 0, 0);
    reset = 1'b0; #1; reset = 1'b1;
    cyc(1, 0, 0, 1);
    chk_all("fall_start", 240, 0, 1, 0);
    for (int i = 0; i < 26; i++) cyc(0, 0, 0, 1);
    chk_all("fall_26", 455, 10, 1, 0);
    cyc(0, 0, 0, 1);
    chk_all("floor_hit", 464, 0, 2, 1);
    cyc(0, 0, 0, 1);
    chk_all("dead_frozen", 464, 0, 2, 1);
    cyc(1, 0, 0, 1);
    chk_all("dead_to_idle", 240, 0, 0, 0);

    // Ceiling: repeated flaps until the top clamp, bird stays alive
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk_all("ceil_start", 240, 0, 1, 0);
    for (int i = 0; i < 29; i++) begin
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 0);
    end
    chk_all("ceil_29", 8, -8, 1, 0);
    cyc(0, 1, 0, 1);
    chk_all("ceil_clamp", 0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk_all("ceil_after", 1, 1, 1, 0);

    // Reset mid-frame, between clock edges and without a tick
    reset = 1'b0;
    #1;
    chk_all("async_reset", 240, 0, 0, 0);
    start_button = 0; flap_button = 0; collided = 0; enable = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // Randomized run against the reference model
    for (int i = 0; i < 4000; i++) begin
      bit s, f, c, e;
      s = ($urandom_range(0, 15) == 0) ? ~start_button : start_button;
      f = ($urandom_range(0, 5) == 0) ? ~flap_button : flap_button;
      c = ($urandom_range(0, 60) == 0);
      e = ($urandom_range(0, 3) == 0);
      cyc(s, f, c, e);
      model_step(s, f, c, e);
      n_total++;
      if (int'(bird_y) == m_y && int'(bird_vy) == m_vy &&
          int'(game_state) == m_st && int'(hit_ground) == m_hit)
        n_pass++;
      else
        $display("FAIL rand%0d: got y=%0d vy=%0d st=%0d hit=%0d expected y=%0d vy=%0d st=%0d hit=%0d",
                 i, bird_y, bird_vy, game_state, hit_ground, m_y, m_vy, m_st, m_hit);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
